// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared definitions for the system-bus interrupt controller.
//   - register byte offsets (decoded on addr[4:2])
//   - controller state encoding
//   - CAUSE register valid-bit position
package irq_ctrl_pkg;

    localparam logic [31:0] IRQ_PENDING_OFF = 32'h00;
    localparam logic [31:0] IRQ_MASK_OFF    = 32'h04;
    localparam logic [31:0] IRQ_CAUSE_OFF   = 32'h08;
    localparam logic [31:0] IRQ_CLEAR_OFF   = 32'h0C;
    localparam logic [31:0] IRQ_EDGE_OFF    = 32'h10;

    localparam int unsigned CAUSE_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } irq_state_t;

    // Word index of a register offset, as compared against addr[4:2].
    function automatic logic [2:0] reg_sel(input logic [31:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational rotating priority encoder.
//   req_i   : request vector
//   start_i : index searched first; search wraps modulo N
//   valid_o : any request set
//   idx_o   : first set index at or after start_i
// With start_i tied to 0 this is a plain fixed-priority encoder (index 0 highest).
module irq_prio_enc #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   start_i,
    output logic         valid_o,
    output logic [3:0]   idx_o
);

    always_comb begin
        int unsigned j;
        valid_o = 1'b0;
        idx_o   = 4'd0;
        j       = 0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            j = int'(start_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = 4'(j);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_sb.sv
// irq_ctrl_sb: memory-mapped interrupt controller on the system bus.
// Merges N_IRQ peripheral interrupt lines into one core request/return pair.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_i, write_enable_i   : bus select and direction
//   addr_i, write_data_i    : register address (addr[4:2]) and write data
//   read_data_o             : registered read data, holds until the next read
//   irq_src_i / irq_ack_o   : peripheral lines in, one-cycle acknowledge out
//   core_irq_req_o/_ret_i   : request to core, return (mret) pulse from core
// Registers: 0x00 PENDING (RO), 0x04 MASK, 0x08 CAUSE (RO), 0x0C CLEAR (W1C), 0x10 EDGE.
// Build option: define IRQ_CTRL_ROUND_ROBIN_EN for rotating priority instead of fixed.
module irq_ctrl_sb
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ      = 8,
    parameter logic [15:0] RESET_MASK = 16'h0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    input  logic [N_IRQ-1:0] irq_src_i,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             core_irq_req_o,
    input  logic             core_irq_ret_i
);

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] edge_q, edge_d;
    logic [N_IRQ-1:0] prev_q;
    logic [3:0]       cause_id_q, cause_id_d;
    logic             cause_valid_q, cause_valid_d;
    logic [31:0]      read_data_q, read_data_d;
    irq_state_t       state_q, state_d;

    logic [N_IRQ-1:0] src_set;
    logic [N_IRQ-1:0] ack_vec;
    logic             wr_en, rd_en;
    logic [2:0]       sel;
    logic             enc_valid;
    logic [3:0]       enc_idx;
    logic [3:0]       ptr;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0], write_data_i[31:N_IRQ]};

    assign wr_en = req_i & write_enable_i;
    assign rd_en = req_i & ~write_enable_i;
    assign sel   = addr_i[4:2];

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [3:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ACK) begin
            ptr_d = (cause_id_q == 4'(N_IRQ - 1)) ? 4'd0 : cause_id_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 4'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 4'd0;
`endif

    irq_prio_enc #(
        .N (N_IRQ)
    ) u_prio_enc (
        .req_i   (pending_q & mask_q),
        .start_i (ptr),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    always_comb begin
        for (int i = 0; i < int'(N_IRQ); i++) begin
            ack_vec[i] = (state_q == ACK) && (cause_id_q == 4'(i));
        end
    end

    assign irq_ack_o      = ack_vec;
    assign core_irq_req_o = (state_q == REQ);
    assign read_data_o    = read_data_q;

    // Register file and pending logic; a new set always overrides clears.
    always_comb begin
        src_set   = (edge_q & irq_src_i & ~prev_q) | (~edge_q & irq_src_i);
        mask_d    = mask_q;
        edge_d    = edge_q;
        pending_d = pending_q;

        if (wr_en) begin
            if (sel == reg_sel(IRQ_MASK_OFF)) begin
                mask_d = write_data_i[N_IRQ-1:0];
            end
            if (sel == reg_sel(IRQ_EDGE_OFF)) begin
                edge_d = write_data_i[N_IRQ-1:0];
            end
            if (sel == reg_sel(IRQ_CLEAR_OFF)) begin
                pending_d = pending_d & ~write_data_i[N_IRQ-1:0];
            end
        end
        pending_d = (pending_d & ~ack_vec) | src_set;

        read_data_d = read_data_q;
        if (rd_en) begin
            case (sel)
                reg_sel(IRQ_PENDING_OFF): read_data_d = 32'(pending_q);
                reg_sel(IRQ_MASK_OFF):    read_data_d = 32'(mask_q);
                reg_sel(IRQ_CAUSE_OFF): begin
                    read_data_d                  = 32'(cause_id_q);
                    read_data_d[CAUSE_VALID_BIT] = cause_valid_q;
                end
                reg_sel(IRQ_EDGE_OFF):    read_data_d = 32'(edge_q);
                default:                  read_data_d = 32'd0;
            endcase
        end
    end

    // Service FSM: CAUSE is latched on entry to REQ and stays fixed until ACK.
    always_comb begin
        state_d       = state_q;
        cause_id_d    = cause_id_q;
        cause_valid_d = cause_valid_q;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    cause_valid_d = 1'b1;
                    cause_id_d    = enc_idx;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (core_irq_ret_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                cause_valid_d = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q     <= '0;
            mask_q        <= RESET_MASK[N_IRQ-1:0];
            edge_q        <= '0;
            prev_q        <= '0;
            cause_id_q    <= 4'd0;
            cause_valid_q <= 1'b0;
            read_data_q   <= 32'd0;
            state_q       <= IDLE;
        end else begin
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            edge_q        <= edge_d;
            prev_q        <= irq_src_i;
            cause_id_q    <= cause_id_d;
            cause_valid_q <= cause_valid_d;
            read_data_q   <= read_data_d;
            state_q       <= state_d;
        end
    end

endmodule
